// File: rtl/map_merger.sv
// map_merger: bias add, requantize, identity add, ReLU/saturate, pack 8 int8 channels per 64-bit word
module map_merger #(
    parameter int NUM_CH  = 64,
    parameter int MULT_W  = 16,
    parameter int SHIFT_W = 5
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [63:0]        psum_acc2map_merger_data,
    input  logic               psum_acc2map_merger_vld,
    output logic               psum_acc2map_merger_rdy,
    input  logic               cfg_we,
    input  logic [5:0]         cfg_addr,
    input  logic [31:0]        cfg_bias,
    input  logic [MULT_W-1:0]  cfg_mult,
    input  logic [SHIFT_W-1:0] cfg_shift,
    input  logic [6:0]         cfg_num_ch,
    input  logic               cfg_relu_en,
    output logic [63:0]        map_merger2out_data,
    output logic               map_merger2out_vld,
    input  logic               map_merger2out_rdy,
    output logic               idle
);
    localparam int PW = 34 + MULT_W + 1;

    logic [31:0]        bias_mem  [NUM_CH];
    logic [MULT_W-1:0]  mult_mem  [NUM_CH];
    logic [SHIFT_W-1:0] shift_mem [NUM_CH];

    logic               en, acc, last_ch, done;
    logic [5:0]         ch_idx_q;
    logic               s1_vld_q, s1_last_q;
    logic signed [33:0] s1_sum_q;
    logic [7:0]         s1_id_q;
    logic [2:0]         s1_lane_q;
    logic [MULT_W-1:0]  s1_mult_q;
    logic [SHIFT_W-1:0] s1_shift_q;
    logic               s2_vld_q, s2_last_q;
    logic signed [PW-1:0] s2_prod_q;
    logic [7:0]         s2_id_q;
    logic [2:0]         s2_lane_q;
    logic [SHIFT_W-1:0] s2_shift_q;
    logic               s3_vld_q, s3_last_q;
    logic [7:0]         s3_res_q;
    logic [2:0]         s3_lane_q;
    logic [63:0]        buf_q, out_data_q, pack_word;
    logic [2:0]         lane_q;
    logic               out_vld_q;
    logic signed [33:0] sum_d;
    logic signed [PW-1:0] prod_d;
    logic signed [PW:0] rnd, r, v;
    logic [7:0]         res_d;

    // Output backpressure freezes the whole pipeline in one cycle.
    assign en  = ~(out_vld_q & ~map_merger2out_rdy);
    assign acc = psum_acc2map_merger_vld & en;
    assign last_ch = {1'b0, ch_idx_q} == cfg_num_ch - 7'd1;
    assign psum_acc2map_merger_rdy = en;
    assign map_merger2out_data = out_data_q;
    assign map_merger2out_vld  = out_vld_q;
    assign idle = ~(s1_vld_q | s2_vld_q | s3_vld_q | out_vld_q) & (lane_q == 3'd0) & (ch_idx_q == 6'd0);

    // Datapath arithmetic for the three stages and the packer merge.
    always_comb begin
        sum_d = {{2{psum_acc2map_merger_data[31]}}, psum_acc2map_merger_data[31:0]}
              + {{10{psum_acc2map_merger_data[55]}}, psum_acc2map_merger_data[55:32]}
              + {{2{bias_mem[ch_idx_q][31]}}, bias_mem[ch_idx_q]};
        prod_d = $signed({{(PW-34){s1_sum_q[33]}}, s1_sum_q}) * $signed({{(PW-MULT_W){1'b0}}, s1_mult_q});
        rnd = (s2_shift_q == '0) ? '0 : ({{PW{1'b0}}, 1'b1} << (s2_shift_q - 1'b1));
        r = ($signed({s2_prod_q[PW-1], s2_prod_q}) + rnd) >>> s2_shift_q;
        v = r + $signed({{(PW-7){s2_id_q[7]}}, s2_id_q});
        v = (cfg_relu_en && v < 0) ? '0 : v;
        res_d = (v > 127) ? 8'h7f : (v < -128) ? 8'h80 : v[7:0];
        pack_word = buf_q;
        pack_word[{s3_lane_q, 3'b000} +: 8] = s3_res_q;
        done = s3_vld_q & (s3_lane_q == 3'd7 | s3_last_q);
    end

    // Requant table write port; contents survive reset.
    always_ff @(posedge clk) begin
        if (cfg_we) begin
            bias_mem[cfg_addr]  <= cfg_bias;
            mult_mem[cfg_addr]  <= cfg_mult;
            shift_mem[cfg_addr] <= cfg_shift;
        end
    end

    // Channel counter and the three compute stages, all stalled together.
    always_ff @(posedge clk) begin
        if (rst) begin
            ch_idx_q <= '0;
            s1_vld_q <= 1'b0;
            s2_vld_q <= 1'b0;
            s3_vld_q <= 1'b0;
        end else if (en) begin
            if (acc) ch_idx_q <= last_ch ? 6'd0 : ch_idx_q + 6'd1;
            s1_vld_q   <= acc;
            s1_sum_q   <= sum_d;
            s1_id_q    <= psum_acc2map_merger_data[63:56];
            s1_lane_q  <= ch_idx_q[2:0];
            s1_last_q  <= last_ch;
            s1_mult_q  <= mult_mem[ch_idx_q];
            s1_shift_q <= shift_mem[ch_idx_q];
            s2_vld_q   <= s1_vld_q;
            s2_prod_q  <= prod_d;
            s2_id_q    <= s1_id_q;
            s2_lane_q  <= s1_lane_q;
            s2_last_q  <= s1_last_q;
            s2_shift_q <= s1_shift_q;
            s3_vld_q   <= s2_vld_q;
            s3_res_q   <= res_d;
            s3_lane_q  <= s2_lane_q;
            s3_last_q  <= s2_last_q;
        end
    end

    // Packer: accumulate bytes, hand off completed words without a bubble.
    always_ff @(posedge clk) begin
        if (rst) begin
            buf_q      <= '0;
            lane_q     <= '0;
            out_data_q <= '0;
            out_vld_q  <= 1'b0;
        end else if (en) begin
            if (map_merger2out_rdy) out_vld_q <= 1'b0;
            if (done) begin
                out_data_q <= pack_word;
                out_vld_q  <= 1'b1;
                buf_q      <= '0;
                lane_q     <= '0;
            end else if (s3_vld_q) begin
                buf_q  <= pack_word;
                lane_q <= s3_lane_q + 3'd1;
            end
        end
    end
endmodule

// File: tb/tb_map_merger.sv
// tb_map_merger: randomized and directed checks of map_merger against a behavioural scoreboard
module tb_map_merger;
    logic        clk = 0, rst = 1;
    logic [63:0] in_data = '0;
    logic        in_vld = 0, in_rdy;
    logic        cfg_we = 0;
    logic [5:0]  cfg_addr = '0;
    logic [31:0] cfg_bias = '0;
    logic [15:0] cfg_mult = '0;
    logic [4:0]  cfg_shift = '0;
    logic [6:0]  cfg_num_ch = 7'd8;
    logic        cfg_relu_en = 0;
    logic [63:0] out_data;
    logic        out_vld, out_rdy = 1, idle;

    int errors = 0, checks = 0, out_cnt = 0;
    longint bias_m[64], mult_m[64], shift_m[64];
    logic [63:0] expq[$];
    logic [63:0] pbuf = '0, last_out = '0;
    int mch = 0;

    map_merger dut (
        .clk(clk), .rst(rst),
        .psum_acc2map_merger_data(in_data), .psum_acc2map_merger_vld(in_vld), .psum_acc2map_merger_rdy(in_rdy),
        .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_bias(cfg_bias), .cfg_mult(cfg_mult), .cfg_shift(cfg_shift),
        .cfg_num_ch(cfg_num_ch), .cfg_relu_en(cfg_relu_en),
        .map_merger2out_data(out_data), .map_merger2out_vld(out_vld), .map_merger2out_rdy(out_rdy),
        .idle(idle)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [7:0] ref_byte(input int p3, input int p1, input int id, input int ch);
        longint s, p, r, v;
        longint sh;
        s = longint'(p3) + longint'(p1) + bias_m[ch];
        p = s * mult_m[ch];
        sh = shift_m[ch];
        r = (sh == 0) ? p : ((p + (longint'(1) <<< (sh - 1))) >>> sh);
        v = r + id;
        if (cfg_relu_en && v < 0) v = 0;
        if (v > 127) v = 127;
        if (v < -128) v = -128;
        return v[7:0];
    endfunction

    always @(negedge clk) begin
        if (rst) begin
            expq.delete();
            pbuf = '0;
            mch = 0;
        end else begin
            if (in_vld && in_rdy) begin
                pbuf[(mch % 8) * 8 +: 8] = ref_byte(int'($signed(in_data[31:0])), int'($signed(in_data[55:32])),
                                                   int'($signed(in_data[63:56])), mch);
                if (mch % 8 == 7 || mch == int'(cfg_num_ch) - 1) begin
                    expq.push_back(pbuf);
                    pbuf = '0;
                end
                mch = (mch == int'(cfg_num_ch) - 1) ? 0 : mch + 1;
            end
            if (out_vld && out_rdy) begin
                out_cnt++;
                last_out = out_data;
                if (expq.size() == 0) chk("unexpected_out", out_data, 64'hx);
                else chk("sb_word", out_data, expq.pop_front());
            end
        end
    end

    task automatic cfg_write(input int a, input int b, input int m, input int s);
        cfg_we = 1; cfg_addr = a[5:0]; cfg_bias = b; cfg_mult = m[15:0]; cfg_shift = s[4:0];
        bias_m[a] = b; mult_m[a] = m; shift_m[a] = s;
        @(posedge clk); #1;
        cfg_we = 0;
    endtask

    task automatic cfg_all(input int b, input int m, input int s);
        for (int i = 0; i < 64; i++) cfg_write(i, b, m, s);
    endtask

    task automatic cfg_rand();
        for (int i = 0; i < 64; i++)
            cfg_write(i, int'($urandom_range(0, 100000)) - 50000, int'($urandom_range(0, 65535)), int'($urandom_range(10, 22)));
    endtask

    task automatic send(input int p3, input int p1, input int id);
        int t = 0;
        in_data = {id[7:0], p1[23:0], p3};
        in_vld = 1;
        @(negedge clk);
        while (!in_rdy && t < 1000) begin @(negedge clk); t++; end
        if (t >= 1000) chk("send_timeout", 64'd0, 64'd1);
        @(posedge clk); #1;
        in_vld = 0;
    endtask

    task automatic send_rand();
        int p3 = ($urandom_range(0, 7) == 0) ? int'($urandom) : int'($urandom_range(0, 8000)) - 4000;
        send(p3, int'($urandom_range(0, 8000)) - 4000, int'($urandom_range(0, 255)) - 128);
    endtask

    task automatic wait_idle(input string tag);
        int t = 0;
        while (!idle && t < 500) begin @(posedge clk); #1; t++; end
        chk({"idle_", tag}, {63'd0, idle}, 64'd1);
        chk({"drained_", tag}, 64'(expq.size()), 64'd0);
    endtask

    initial begin
        int c0;
        repeat (3) @(posedge clk);
        #1 rst = 0;
        chk("rst_out_vld", {63'd0, out_vld}, 64'd0);
        chk("rst_out_data", out_data, 64'd0);
        chk("rst_idle", {63'd0, idle}, 64'd1);
        chk("rst_rdy", {63'd0, in_rdy}, 64'd1);

        cfg_all(0, 1, 0);
        cfg_num_ch = 8;
        for (int i = 0; i < 8; i++) send(10, 5, 3);
        repeat (2) @(posedge clk);
        #1 chk("lat_not_yet", {63'd0, out_vld}, 64'd0);
        @(posedge clk); #1;
        chk("lat_out_vld", {63'd0, out_vld}, 64'd1);
        chk("lat_data", out_data, 64'h1212121212121212);
        wait_idle("t1");

        cfg_write(0, 0, 3, 4);
        cfg_write(1, 0, 3, 4);
        cfg_num_ch = 2;
        send(100, 0, 0);
        send(-100, 0, 0);
        wait_idle("t2");
        chk("round_word", last_out, 64'h000000000000ED13);

        cfg_all(0, 1, 0);
        send(1000, 0, 0);
        send(-1000, 0, 0);
        wait_idle("t3a");
        chk("sat_word", last_out, 64'h000000000000807F);
        cfg_relu_en = 1;
        send(1000, 0, 0);
        send(-1000, 0, 0);
        wait_idle("t3b");
        chk("relu_word", last_out, 64'h000000000000007F);
        cfg_relu_en = 0;

        cfg_rand();
        cfg_num_ch = 8;
        c0 = out_cnt;
        fork
            for (int i = 0; i < 32; i++) send_rand();
            begin
                int t = 0;
                while (!out_vld && t < 500) begin @(posedge clk); #1; t++; end
                chk("stall_first_vld", {63'd0, out_vld}, 64'd1);
                out_rdy = 0;
                repeat (10) @(posedge clk);
                @(negedge clk);
                chk("stall_rdy", {63'd0, in_rdy}, 64'd0);
                chk("stall_vld_hold", {63'd0, out_vld}, 64'd1);
                repeat (9) @(posedge clk);
                #1 out_rdy = 1;
            end
        join
        wait_idle("t4");
        chk("stall_count", 64'(out_cnt - c0), 64'd4);

        cfg_relu_en = 1;
        cfg_num_ch = 12;
        c0 = out_cnt;
        for (int i = 0; i < 24; i++) send_rand();
        wait_idle("t5");
        chk("grp12_count", 64'(out_cnt - c0), 64'd4);
        chk("grp12_upper_zero", {32'd0, last_out[63:32]}, 64'd0);
        cfg_relu_en = 0;

        cfg_all(0, 1, 0);
        cfg_num_ch = 8;
        c0 = out_cnt;
        for (int i = 0; i < 5; i++) send(10, 5, 3);
        rst = 1;
        @(posedge clk); #1;
        rst = 0;
        chk("midrst_vld", {63'd0, out_vld}, 64'd0);
        chk("midrst_idle", {63'd0, idle}, 64'd1);
        for (int i = 0; i < 8; i++) send(10, 5, 3);
        wait_idle("t6");
        chk("midrst_count", 64'(out_cnt - c0), 64'd1);
        chk("midrst_word", last_out, 64'h1212121212121212);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
